// File: rtl/instr_prefetch_r0_if.sv
// Prefetch-unit bus: redirect/IF-stage handshake plus instruction memory req/ack channel.
interface instr_prefetch_r0_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  if_ready;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_pcplus4;
  logic [DATA_WIDTH-1:0] if_instr;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    input  redirect, redirect_pc, if_ready, imem_ack, imem_rdata,
    output if_valid, if_pc, if_pcplus4, if_instr, imem_req, imem_addr
  );

  modport slave (
    output redirect, redirect_pc, if_ready, imem_ack, imem_rdata,
    input  if_valid, if_pc, if_pcplus4, if_instr, imem_req, imem_addr
  );
endinterface

// File: rtl/instr_prefetch_r0.sv
// Instruction prefetch unit: one-outstanding req/ack fetch engine filling a small {pc, instr} queue
// drained by the IF stage; redirects flush the queue and restart fetch at the new PC.
module instr_prefetch_r0 #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_prefetch_r0_if.master bus
);

  localparam int                    PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                    CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]      FULL     = CNT_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_MASK  = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] PC_START = RESET_PC & PC_MASK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] disc_addr_q, disc_addr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];

  logic                  head_valid;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  assign head_valid = (count_q != '0);
  assign fetch_addr = fetch_pc_q[ADDR_WIDTH+1:2];
  // Redirect voids both the returning word and the IF-stage pop of this cycle.
  assign push = (state_q == S_REQ) && bus.imem_ack && !bus.redirect;
  assign pop  = head_valid && bus.if_ready && !bus.redirect;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fetch_pc_d  = fetch_pc_q;
    disc_addr_d = disc_addr_q;
    if (bus.redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = bus.redirect_pc & PC_MASK;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // The abandoned request keeps its address on the bus until its ack arrives.
    if ((state_q == S_REQ) && !bus.imem_ack && bus.redirect) begin
      disc_addr_d = fetch_addr;
    end
  end

  // A new request starts only if a slot is guaranteed free when its data lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (count_d < FULL) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.imem_ack)       state_d = (count_d < FULL) ? S_REQ : S_IDLE;
        else if (bus.redirect)  state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (bus.imem_ack) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req   = (state_q != S_IDLE);
    bus.imem_addr  = (state_q == S_DISCARD) ? disc_addr_q : fetch_addr;
    bus.if_valid   = head_valid;
    bus.if_pc      = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    bus.if_pcplus4 = head_valid ? pc_mem_q[rd_ptr_q] + DATA_WIDTH'(4) : '0;
    bus.if_instr   = head_valid ? instr_mem_q[rd_ptr_q] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= PC_START;
      disc_addr_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      disc_addr_q <= disc_addr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // NOTE: queue storage is not reset; outputs are gated by if_valid, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

endmodule
